// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// through a single full-subtractor cell and a borrow flop. Results (diff,
// bout, ovf) are published in one transfer on the completion edge, together
// with a one-cycle done pulse.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_nxt;

  // Operand shift registers, borrow flop and bit counter
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             brw;
  logic [CW-1:0]    cnt;
  // Difference bits produced so far; the final bit is appended on completion
  logic [WIDTH-2:0] work;
  // Operand sign bits captured at accept time for the overflow flag
  logic             amsb;
  logic             bmsb;

  logic             accept;
  logic             last;
  logic             d_bit;
  logic             brw_nxt;
  logic [WIDTH-1:0] res_full;

  // Full-subtractor cell: difference bit
  function automatic logic fs_diff(input logic x, input logic y, input logic bi);
    return x ^ y ^ bi;
  endfunction

  // Full-subtractor cell: borrow out
  function automatic logic fs_borrow(input logic x, input logic y, input logic bi);
    return (~x & y) | (~(x ^ y) & bi);
  endfunction

  // Subtractor cell, accept/last decode and next-state selection
  always_comb begin
    state_nxt = state_q;
    accept    = start && (state_q != SHIFT);
    last      = (state_q == SHIFT) && (cnt == LAST);
    d_bit     = fs_diff(sa[0], sb[0], brw);
    brw_nxt   = fs_borrow(sa[0], sb[0], brw);
    res_full  = {d_bit, work};
    case (state_q)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (last) state_nxt = DONE;
      DONE:    state_nxt = accept ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Operand load, serial bit processing and result publish
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa   <= '0;
      sb   <= '0;
      brw  <= 1'b0;
      cnt  <= '0;
      work <= '0;
      amsb <= 1'b0;
      bmsb <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        sa   <= a;
        sb   <= b;
        brw  <= bin;
        cnt  <= '0;
        work <= '0;
        amsb <= a[WIDTH-1];
        bmsb <= b[WIDTH-1];
        busy <= 1'b1;
      end else if (state_q == SHIFT) begin
        sa   <= sa >> 1;
        sb   <= sb >> 1;
        brw  <= brw_nxt;
        work <= res_full[WIDTH-1:1];
        cnt  <= cnt + CW'(1);
        if (last) begin
          // Publish the whole result at once; outputs never show partial data
          diff <= res_full;
          bout <= brw_nxt;
          ovf  <= (amsb ^ bmsb) & (d_bit ^ amsb);
          busy <= 1'b0;
          done <= 1'b1;
          cnt  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: an 8-bit instance for the main
// scenarios and a 2-bit instance swept over every operand/borrow combination.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       bin = 1'b0;
  logic       busy, done, bout, ovf;
  logic [7:0] diff;

  logic       start2 = 1'b0;
  logic [1:0] a2 = '0;
  logic [1:0] b2 = '0;
  logic       bin2 = 1'b0;
  logic       busy2, done2, bout2, ovf2;
  logic [1:0] diff2;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
  );

  serial_subtractor #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .bin(bin2),
    .busy(busy2), .done(done2), .diff(diff2), .bout(bout2), .ovf(ovf2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands with start for exactly one rising edge
  task automatic launch(input logic [7:0] av, input logic [7:0] bv, input logic bi);
    @(negedge clk);
    a = av; b = bv; bin = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count negedges until done, also counting cycles with busy high
  task automatic wait_done(output int n, output int busyc);
    n = 0; busyc = 0;
    while (!done && n < 40) begin
      if (busy) busyc++;
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n, bc, dcount, t0, t1, t2, ndone;
    logic [2:0] r;
    int sa_i, sb_i, sres;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 5 - 3: latency and busy duration
    launch(8'h05, 8'h03, 1'b0);
    wait_done(n, bc);
    chk("op1_done", done, 1);
    chk("op1_latency", n, 8);
    chk("op1_busy_cycles", bc, 8);
    chk("op1_diff", diff, 8'h02);
    chk("op1_bout", bout, 0);
    chk("op1_ovf", ovf, 0);
    @(negedge clk);
    chk("op1_done_pulse", done, 0);

    // 3 - 5 wraps with borrow
    launch(8'h03, 8'h05, 1'b0);
    wait_done(n, bc);
    chk("op2_diff", diff, 8'hFE);
    chk("op2_bout", bout, 1);
    chk("op2_ovf", ovf, 0);

    // Start during busy is ignored; diff holds mid-operation
    launch(8'h10, 8'h01, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("hold_diff_mid", diff, 8'hFE);
    chk("hold_bout_mid", bout, 1);
    a = 8'hFF; b = 8'h0F; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n, bc);
    chk("ign_latency", n, 5);
    chk("ign_diff", diff, 8'h0F);
    chk("ign_bout", bout, 0);
    chk("ign_ovf", ovf, 0);
    dcount = 0;
    repeat (14) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("ign_no_second_done", dcount, 0);
    chk("ign_idle", busy, 0);

    // Signed overflow cases
    launch(8'h80, 8'h01, 1'b0);
    wait_done(n, bc);
    chk("ovf1_diff", diff, 8'h7F);
    chk("ovf1_bout", bout, 0);
    chk("ovf1_ovf", ovf, 1);
    launch(8'h7F, 8'hFF, 1'b0);
    wait_done(n, bc);
    chk("ovf2_diff", diff, 8'h80);
    chk("ovf2_bout", bout, 1);
    chk("ovf2_ovf", ovf, 1);

    // Borrow-in with equal operands
    launch(8'h00, 8'h00, 1'b1);
    wait_done(n, bc);
    chk("bin0_diff", diff, 8'hFF);
    chk("bin0_bout", bout, 1);
    chk("bin0_ovf", ovf, 0);
    launch(8'h5A, 8'h5A, 1'b1);
    wait_done(n, bc);
    chk("bin5a_diff", diff, 8'hFF);
    chk("bin5a_bout", bout, 1);
    chk("bin5a_ovf", ovf, 0);

    // Start held high: one result every 9 cycles
    @(negedge clk);
    a = 8'h20; b = 8'h10; bin = 1'b0; start = 1'b1;
    t0 = -1; t1 = -1; t2 = -1; ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) begin
        if (ndone == 0) t0 = c;
        else if (ndone == 1) t1 = c;
        else if (ndone == 2) t2 = c;
        ndone++;
      end
    end
    start = 1'b0;
    chk("b2b_count_ge3", (ndone >= 3), 1);
    chk("b2b_gap1", t1 - t0, 9);
    chk("b2b_gap2", t2 - t1, 9);
    chk("b2b_diff", diff, 8'h10);
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_drained", busy, 0);
    @(negedge clk);

    // Reset mid-operation
    launch(8'h33, 8'h11, 1'b0);
    repeat (4) @(negedge clk);
    chk("mid_busy_before_rst", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_diff", diff, 0);
    chk("mrst_bout", bout, 0);
    chk("mrst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    chk("mrst_quiet_after", dcount, 0);
    launch(8'h33, 8'h11, 1'b0);
    wait_done(n, bc);
    chk("mrst_next_latency", n, 8);
    chk("mrst_next_diff", diff, 8'h22);
    chk("mrst_next_bout", bout, 0);

    // Exhaustive sweep on the 2-bit instance
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      a2 = i[1:0]; b2 = i[3:2]; bin2 = i[4]; start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      n = 0;
      while (!done2 && n < 10) begin
        @(negedge clk);
        n++;
      end
      r = {1'b0, a2} - {1'b0, b2} - {2'b00, bin2};
      sa_i = a2[1] ? int'(a2) - 4 : int'(a2);
      sb_i = b2[1] ? int'(b2) - 4 : int'(b2);
      sres = sa_i - sb_i - int'(bin2);
      chk($sformatf("w2_lat_%0d", i), n, 2);
      chk($sformatf("w2_diff_%0d", i), diff2, r[1:0]);
      chk($sformatf("w2_bout_%0d", i), bout2, r[2]);
      chk($sformatf("w2_ovf_%0d", i), ovf2, (sres < -2 || sres > 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
